// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential RV32M divider.
//   div_op_t : operation encoding as presented on the op port
//   state_t  : divider control states
//   is_signed/is_rem : decode helpers for div_op_t
package div_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StAdj  = 2'b10,
    StDone = 2'b11
  } state_t;

  function automatic logic is_signed(input div_op_t op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_rem(input div_op_t op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/seq_div_if.sv
// Start/done handshake bundle between the execute stage and seq_div.
//   master : issues start/op/dividend/divisor, observes busy/done/result
//   slave  : the divider side
interface seq_div_if
  import div_pkg::*;
#(
  parameter int unsigned BitWidth = 32
) ();

  logic                start;
  div_op_t             op;
  logic [BitWidth-1:0] dividend;
  logic [BitWidth-1:0] divisor;
  logic                busy;
  logic                done;
  logic [BitWidth-1:0] result;

  modport master (
    output start, op, dividend, divisor,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor,
    output busy, done, result
  );

endinterface

// File: rtl/add_sub.sv
// Width-bit adder/subtractor.
//   a, b      : operands
//   sub1_add0 : 1 computes a - b, 0 computes a + b
//   sum       : Width-bit result
//   cout      : carry out; in subtract mode 1 means no borrow (a >= b)
module add_sub #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             sub1_add0,
  output logic [Width-1:0] sum,
  output logic             cout
);

  logic [Width-1:0] b_eff;

  always_comb begin
    b_eff       = sub1_add0 ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{Width{1'b0}}, sub1_add0};
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : seq_div_if slave (start/op/dividend/divisor in, busy/done/result out)
// Normal ops take BitWidth CALC cycles, one ADJ cycle and one DONE cycle.
// Divide-by-zero and signed overflow are resolved at start and pass through ADJ
// without touching result, so done still arrives two cycles after start.
module seq_div
  import div_pkg::*;
#(
  parameter int unsigned BitWidth = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_div_if.slave  bus
);

  localparam int unsigned CntW = $clog2(BitWidth);
  localparam logic [BitWidth-1:0] MinNeg = {1'b1, {(BitWidth-1){1'b0}}};

  function automatic logic [BitWidth-1:0] negate(input logic [BitWidth-1:0] x);
    return ~x + BitWidth'(1);
  endfunction

  state_t              state_q, state_d;
  div_op_t             op_q, op_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                spec_q, spec_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [BitWidth-1:0] quo_q, quo_d;   // holds |dividend| initially, shifts out MSB first
  logic [BitWidth-1:0] rem_q, rem_d;
  logic [BitWidth-1:0] dvs_q, dvs_d;
  logic [BitWidth-1:0] result_q, result_d;

  logic [BitWidth:0]   trial;
  logic [BitWidth:0]   diff;
  logic                no_borrow;
  logic                unused_diff_msb;

  assign trial = {rem_q, quo_q[BitWidth-1]};

  add_sub #(
    .Width (BitWidth + 1)
  ) u_add_sub (
    .a         (trial),
    .b         ({1'b0, dvs_q}),
    .sub1_add0 (1'b1),
    .sum       (diff),
    .cout      (no_borrow)
  );

  // The partial remainder stays below the divisor, so the difference MSB is zero when kept.
  assign unused_diff_msb = diff[BitWidth];

  always_comb begin
    logic a_neg;
    logic b_neg;
    state_d  = state_q;
    op_d     = op_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    spec_d   = spec_q;
    count_d  = count_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    a_neg    = 1'b0;
    b_neg    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_neg   = is_signed(bus.op) & bus.dividend[BitWidth-1];
          b_neg   = is_signed(bus.op) & bus.divisor[BitWidth-1];
          op_d    = bus.op;
          quo_d   = a_neg ? negate(bus.dividend) : bus.dividend;
          dvs_d   = b_neg ? negate(bus.divisor) : bus.divisor;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          count_d = CntW'(BitWidth - 1);
          rem_d   = '0;
          if (bus.divisor == '0) begin
            result_d = is_rem(bus.op) ? bus.dividend : '1;
            spec_d   = 1'b1;
            state_d  = StAdj;
          end else if (is_signed(bus.op) && (bus.dividend == MinNeg) && (bus.divisor == '1)) begin
            result_d = is_rem(bus.op) ? '0 : MinNeg;
            spec_d   = 1'b1;
            state_d  = StAdj;
          end else begin
            spec_d  = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d   = no_borrow ? diff[BitWidth-1:0] : trial[BitWidth-1:0];
        quo_d   = {quo_q[BitWidth-2:0], no_borrow};
        count_d = count_q - CntW'(1);
        if (count_q == '0) begin
          state_d = StAdj;
        end
      end
      StAdj: begin
        if (!spec_q) begin
          if (is_rem(op_q)) begin
            result_d = r_neg_q ? negate(rem_q) : rem_q;
          end else begin
            result_d = q_neg_q ? negate(quo_q) : quo_q;
          end
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      spec_q   <= 1'b0;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      spec_q   <= spec_d;
      count_q  <= count_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == StCalc) || (state_q == StAdj);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed and randomized checks of seq_div against an arithmetic reference model.
module tb_seq_div;
  import div_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seq_div_if #(.BitWidth(32)) bus ();

  seq_div #(
    .BitWidth (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      2'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'd2: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    if (b == 0) return 2;
    if ((op == 2'd0 || op == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one op; returns result, done latency (0 on timeout) and busy-profile violations.
  // If restart_cyc > 0, a conflicting start is raised in that cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int restart_cyc, output logic [31:0] res, output int lat,
                       output int busy_err);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = div_op_t'(op);
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    lat          = 0;
    busy_err     = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == restart_cyc) begin
        bus.start    = 1'b1;
        bus.op       = OpDivu;
        bus.dividend = 32'd999;
        bus.divisor  = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = cyc;
        if (bus.busy) busy_err++;
        break;
      end
      if (!bus.busy) busy_err++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    res       = bus.result;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          berr;
    int          hold_err;
    int          done_seen;

    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.op       = OpDiv;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst_n = 1'b1;

    do_op(2'd1, 32'd100, 32'd7, 0, res, lat, berr);
    check("divu_100_7", res, 32'd14);
    check("divu_100_7_lat", 32'(lat), 32'd34);
    check("divu_100_7_busy", 32'(berr), 32'd0);

    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, res, lat, berr);
    check("rem_m7_2", res, 32'hFFFF_FFFF);
    do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, res, lat, berr);
    check("div_m7_2", res, 32'hFFFF_FFFD);
    check("div_m7_2_lat", 32'(lat), 32'd34);

    do_op(2'd1, 32'd5, 32'd0, 0, res, lat, berr);
    check("divu_by0", res, 32'hFFFF_FFFF);
    check("divu_by0_lat", 32'(lat), 32'd2);
    check("divu_by0_busy", 32'(berr), 32'd0);
    do_op(2'd3, 32'd5, 32'd0, 0, res, lat, berr);
    check("remu_by0", res, 32'd5);
    check("remu_by0_lat", 32'(lat), 32'd2);
    do_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0, res, lat, berr);
    check("rem_by0", res, 32'hFFFF_FFF0);

    do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, berr);
    check("div_ovf", res, 32'h8000_0000);
    check("div_ovf_lat", 32'(lat), 32'd2);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, berr);
    check("rem_ovf", res, 32'd0);
    do_op(2'd1, 32'h8000_0000, 32'd1, 0, res, lat, berr);
    check("divu_min_1", res, 32'h8000_0000);
    check("divu_min_1_lat", 32'(lat), 32'd34);
    do_op(2'd0, 32'h8000_0000, 32'd3, 0, res, lat, berr);
    check("div_min_3", res, 32'hD555_5556);

    do_op(2'd1, 32'd100, 32'd7, 5, res, lat, berr);
    check("restart_ignored", res, 32'd14);
    check("restart_lat", 32'(lat), 32'd34);

    held     = res;
    hold_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.result !== held || bus.done !== 1'b0) hold_err++;
    end
    check("result_hold", 32'(hold_err), 32'd0);

    // Reset in the middle of a DIV.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = OpDiv;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_result", bus.result, 32'd0);
    rst_n     = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("midreset_no_done", 32'(done_seen), 32'd0);
    do_op(2'd0, 32'd1000, 32'd7, 0, res, lat, berr);
    check("after_reset_div", res, 32'd142);
    check("after_reset_lat", 32'(lat), 32'd34);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = -32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_op(rop, ra, rb, 0, res, lat, berr);
      check($sformatf("rand%0d_op%0d_%08h_%08h", i, rop, ra, rb), res, model(rop, ra, rb));
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(model_latency(rop, ra, rb)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
